// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants and types for the EX stage
// Holds the datapath defaults, ALU op codes and the multiplier FSM state enum.
package ex_pkg;

    localparam int EX_DW = 16;
    localparam int EX_RW = 3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - sequential shift-add multiplier (low DW bits of product)
// Ports: clk, reset (async active-low), start (request, honoured only in IDLE),
//        a/b operands (captured on start), busy (iterating), done (product valid
//        for one cycle), product.
// Sixteen iterations, one per cycle, then a single DONE cycle before IDLE.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int DW = EX_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);

    mul_state_t    state;
    mul_state_t    state_nx;
    logic [3:0]    count;
    logic [DW-1:0] acc;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BUSY;
            BUSY:    if (count == 4'd15) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Multiplicand walks left while the multiplier walks right; only the low
    // DW bits are kept, which is all the pipeline needs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= '0;
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                    end
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == BUSY);
    assign done    = (state == DONE);
    assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX pipeline stage: ALU, optional multiplier, EX/MEM register
// Ports: clk, reset (async active-low); *_id decode-side operands and controls;
//        *_ex registered result (also memory address), store data, controls,
//        destination, valid and flags; stall_ex (combinational hold to decode).
// Build option: define EX_MUL_EN to include the sequential multiplier for op 11;
//        otherwise op 11 yields 0 in one cycle and stall_ex is tied low.
module execute_stage
    import ex_pkg::*;
#(
    parameter int DW = EX_DW,
    parameter int RW = EX_RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_id,
    input  logic [3:0]    alu_op_id,
    input  logic [DW-1:0] a_id,
    input  logic [DW-1:0] b_id,
    input  logic [DW-1:0] data_id,
    input  logic          mem_rw_id,
    input  logic          mem_en_id,
    input  logic          mem_mux_sel_id,
    input  logic          wb_en_id,
    input  logic [RW-1:0] rd_id,
    output logic [DW-1:0] ans_ex,
    output logic [DW-1:0] DM_data,
    output logic          mem_rw_ex,
    output logic          mem_en_ex,
    output logic          mem_mux_sel_ex,
    output logic          wb_en_ex,
    output logic [RW-1:0] rd_ex,
    output logic          valid_ex,
    output logic          zero_ex,
    output logic          carry_ex,
    output logic          ovf_ex,
    output logic          stall_ex
);

    logic [DW:0]   sum_ab;
    logic [DW:0]   dif_ab;
    logic [3:0]    shamt;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_o;
    logic [DW-1:0] ex_res;
    logic          stall;

    assign sum_ab = {1'b0, a_id} + {1'b0, b_id};
    assign dif_ab = {1'b0, a_id} + {1'b0, ~b_id} + {{DW{1'b0}}, 1'b1};
    assign shamt  = b_id[3:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (alu_op_id)
            OP_ADD: begin
                alu_res = sum_ab[DW-1:0];
                alu_c   = sum_ab[DW];
                alu_o   = (a_id[DW-1] == b_id[DW-1]) && (sum_ab[DW-1] != a_id[DW-1]);
            end
            OP_SUB: begin
                alu_res = dif_ab[DW-1:0];
                alu_c   = dif_ab[DW];
                alu_o   = (a_id[DW-1] != b_id[DW-1]) && (dif_ab[DW-1] != a_id[DW-1]);
            end
            OP_AND:  alu_res = a_id & b_id;
            OP_OR:   alu_res = a_id | b_id;
            OP_XOR:  alu_res = a_id ^ b_id;
            OP_NOT:  alu_res = ~a_id;
            OP_SHL:  alu_res = a_id << shamt;
            OP_SHR:  alu_res = a_id >> shamt;
            OP_SRA:  alu_res = $signed(a_id) >>> shamt;
            OP_PASS: alu_res = b_id;
            OP_SLT:  alu_res = ($signed(a_id) < $signed(b_id)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic          mul_req;
    logic          mul_busy;
    logic          mul_done;
    logic [DW-1:0] mul_product;

    assign mul_req = valid_id && (alu_op_id == OP_MUL);

    ex_mul_seq #(.DW(DW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_req),
        .a       (a_id),
        .b       (b_id),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The MUL still held by decode during DONE is the one just completed, so
    // DONE does not raise stall and lets it retire with the product.
    assign stall  = reset && ((mul_req && !mul_busy && !mul_done) || mul_busy);
    assign ex_res = mul_done ? mul_product : alu_res;
`else
    assign stall  = 1'b0;
    assign ex_res = alu_res;
`endif

    assign stall_ex = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_ex         <= '0;
            DM_data        <= '0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            mem_mux_sel_ex <= 1'b0;
            wb_en_ex       <= 1'b0;
            rd_ex          <= '0;
            valid_ex       <= 1'b0;
            zero_ex        <= 1'b0;
            carry_ex       <= 1'b0;
            ovf_ex         <= 1'b0;
        end else if (stall || !valid_id) begin
            ans_ex         <= '0;
            DM_data        <= '0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            mem_mux_sel_ex <= 1'b0;
            wb_en_ex       <= 1'b0;
            rd_ex          <= '0;
            valid_ex       <= 1'b0;
            zero_ex        <= 1'b0;
            carry_ex       <= 1'b0;
            ovf_ex         <= 1'b0;
        end else begin
            ans_ex         <= ex_res;
            DM_data        <= data_id;
            mem_rw_ex      <= mem_rw_id;
            mem_en_ex      <= mem_en_id;
            mem_mux_sel_ex <= mem_mux_sel_id;
            wb_en_ex       <= wb_en_id;
            rd_ex          <= rd_id;
            valid_ex       <= 1'b1;
            zero_ex        <= (ex_res == '0);
            carry_ex       <= alu_c;
            ovf_ex         <= alu_o;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage
module tb_execute_stage;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_SHL = 4'd6, T_SHR = 4'd7,
                           T_SRA = 4'd8, T_PASS = 4'd9, T_MUL = 4'd11;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_id;
    logic [3:0]  alu_op_id;
    logic [15:0] a_id, b_id, data_id;
    logic        mem_rw_id, mem_en_id, mem_mux_sel_id, wb_en_id;
    logic [2:0]  rd_id;
    logic [15:0] ans_ex, DM_data;
    logic        mem_rw_ex, mem_en_ex, mem_mux_sel_ex, wb_en_ex;
    logic [2:0]  rd_ex;
    logic        valid_ex, zero_ex, carry_ex, ovf_ex, stall_ex;
    logic [42:0] all_out;

    assign all_out = {ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_ex, wb_en_ex,
                      rd_ex, valid_ex, zero_ex, carry_ex, ovf_ex};

    execute_stage dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .alu_op_id(alu_op_id),
        .a_id(a_id), .b_id(b_id), .data_id(data_id), .mem_rw_id(mem_rw_id),
        .mem_en_id(mem_en_id), .mem_mux_sel_id(mem_mux_sel_id), .wb_en_id(wb_en_id),
        .rd_id(rd_id), .ans_ex(ans_ex), .DM_data(DM_data), .mem_rw_ex(mem_rw_ex),
        .mem_en_ex(mem_en_ex), .mem_mux_sel_ex(mem_mux_sel_ex), .wb_en_ex(wb_en_ex),
        .rd_ex(rd_ex), .valid_ex(valid_ex), .zero_ex(zero_ex), .carry_ex(carry_ex),
        .ovf_ex(ovf_ex), .stall_ex(stall_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ans;
        logic [15:0] dm;
        logic [3:0]  ctl;
        logic [2:0]  rd;
        logic        z, c, o;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the op definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, b, d,
                                   input logic [3:0] ctl, input logic [2:0] rd);
        exp_t e;
        int ua, ub, sa, sb, sh, r;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        sh = int'(b[3:0]);
        e.c = 1'b0; e.o = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; e.c = (r > 65535); e.o = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1: begin r = ua - ub; e.c = (ua >= ub); e.o = (sa - sb > 32767) || (sa - sb < -32768); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = 65535 - ua;
            4'd6: r = ua * (1 << sh);
            4'd7: r = ua / (1 << sh);
            4'd8: r = sa >>> sh;
            4'd9: r = ub;
            4'd10: r = (sa < sb) ? 1 : 0;
            4'd11: r = MUL_EN ? ua * ub : 0;
            default: r = 0;
        endcase
        e.ans = r[15:0];
        e.z   = (e.ans == 16'h0);
        e.dm  = d;
        e.ctl = ctl;
        e.rd  = rd;
        return e;
    endfunction

    // Monitor: every cycle out of reset, a valid output is popped and compared;
    // anything else must be a clean all-zero bubble.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && mon_en) begin
            if (valid_ex) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ans_ex", ans_ex, e.ans);
                    chk("DM_data", DM_data, e.dm);
                    chk("ctl_ex", {wb_en_ex, mem_mux_sel_ex, mem_en_ex, mem_rw_ex}, e.ctl);
                    chk("rd_ex", rd_ex, e.rd);
                    chk("flags_zco", {zero_ex, carry_ex, ovf_ex}, {e.z, e.c, e.o});
                end
            end else begin
                chk("bubble_zero", all_out, 0);
            end
        end
    end

    // Issue one instruction, holding it while stall_ex is high; ctl = {wb, mux, en, rw}.
    task automatic send(input bit v, input logic [3:0] op, input logic [15:0] a, b, d,
                        input logic [3:0] ctl, input logic [2:0] rd);
        int n;
        bit s;
        valid_id = v; alu_op_id = op; a_id = a; b_id = b; data_id = d;
        mem_rw_id = ctl[0]; mem_en_id = ctl[1]; mem_mux_sel_id = ctl[2]; wb_en_id = ctl[3];
        rd_id = rd;
        if (v) sb_q.push_back(model(op, a, b, d, ctl, rd));
        n = 0;
        forever begin
            @(negedge clk);
            s = stall_ex;
            if (s) n++;
            @(posedge clk);
            #1;
            if (!s || n > 40) break;
        end
        chk("stall_cycles", n, (MUL_EN && v && op == T_MUL) ? 17 : 0);
    endtask

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000 | 16'($urandom_range(0, 255));
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        valid_id = 1'b1; alu_op_id = T_MUL; a_id = 16'($urandom); b_id = 16'($urandom);
        data_id = 16'($urandom); mem_rw_id = 1'b1; mem_en_id = 1'b1;
        mem_mux_sel_id = 1'b1; wb_en_id = 1'b1; rd_id = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", all_out, 0);
            chk("reset_stall", stall_ex, 0);
            alu_op_id = 4'($urandom); a_id = 16'($urandom);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        send(1, T_ADD, 16'd3, 16'd4, 16'h0, 4'b1000, 3'd1);
        send(1, T_ADD, 16'h7FFF, 16'h0001, 16'h0, 4'b1000, 3'd2);
        send(1, T_SUB, 16'd5, 16'd5, 16'h0, 4'b1000, 3'd3);
        send(1, T_SRA, 16'h8000, 16'd15, 16'h0, 4'b1000, 3'd4);
        send(1, T_SHR, 16'h8000, 16'd15, 16'h0, 4'b1000, 3'd4);
        send(1, T_SHL, 16'h0001, 16'd0, 16'h0, 4'b1000, 3'd4);
        send(1, T_PASS, 16'h1234, 16'h0040, 16'hBEEF, 4'b0011, 3'd0);
        send(1, T_MUL, 16'd300, 16'd200, 16'h0, 4'b1000, 3'd5);
        send(1, T_ADD, 16'd10, 16'd20, 16'h0, 4'b1000, 3'd6);
        send(1, T_MUL, 16'hFFFF, 16'hFFFF, 16'h0, 4'b1000, 3'd1);
        send(1, T_MUL, 16'd7, 16'd9, 16'h0, 4'b1000, 3'd2);
        send(0, T_ADD, 16'd1, 16'd1, 16'h0, 4'b1111, 3'd7);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == T_MUL && $urandom_range(0, 2) != 0) op = T_PASS;
            send($urandom_range(0, 7) != 0, op, rnd_operand(), rnd_operand(),
                 16'($urandom), 4'($urandom), 3'($urandom));
        end

        for (int i = 0; i < 3; i++) send(0, T_ADD, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd0);
        chk("queue_drained", sb_q.size(), 0);

        // Abort a multiply partway through with reset.
        mon_en = 1'b0;
        valid_id = 1'b1; alu_op_id = T_MUL; a_id = 16'd1000; b_id = 16'd1000;
        data_id = 16'h5555; mem_rw_id = 1'b0; mem_en_id = 1'b0; mem_mux_sel_id = 1'b0;
        wb_en_id = 1'b1; rd_id = 3'd3;
        for (int i = 0; i < 8; i++) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_stall", stall_ex, 0);
        chk("abort_outputs", all_out, 0);
        @(negedge clk);
        chk("abort_hold_outputs", all_out, 0);
        valid_id = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        send(1, T_MUL, 16'd2, 16'd3, 16'h0, 4'b1000, 3'd2);
        send(1, T_ADD, 16'h8000, 16'h8000, 16'h0, 4'b1000, 3'd1);
        for (int i = 0; i < 3; i++) send(0, T_ADD, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd0);
        chk("queue_drained_end", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 16-bit pipeline, between decode and the data-memory stage. Performs the ALU operation on decoded operands, optionally runs a sequential shift-add multiply with a stall handshake back to decode, and registers the result and memory-control fields into the EX/MEM pipeline register. The registered result doubles as the data-memory address.

## Interface
- `DW`, 16: datapath width.
- `RW`, 3: destination-register index width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `valid_id` in 1: decode presents an instruction.
- `alu_op_id` in 4: operation code (see Operation).
- `a_id` in DW: operand A.
- `b_id` in DW: operand B or immediate.
- `data_id` in DW: store data.
- `mem_rw_id` in 1: memory write enable.
- `mem_en_id` in 1: memory access enable.
- `mem_mux_sel_id` in 1: writeback source select (0 = ALU result, 1 = memory).
- `wb_en_id` in 1: register writeback enable.
- `rd_id` in RW: destination register.
- `ans_ex` out DW: registered result / memory address.
- `DM_data` out DW: registered store data.
- `mem_rw_ex`, `mem_en_ex`, `mem_mux_sel_ex`, `wb_en_ex` out 1: registered controls.
- `rd_ex` out RW: registered destination register.
- `valid_ex` out 1: EX/MEM register holds a real instruction.
- `zero_ex`, `carry_ex`, `ovf_ex` out 1: registered flags.
- `stall_ex` out 1: decode must hold its outputs stable.

## Operation
- Op codes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOT a.
  - 6 SHL a by b[3:0]; 7 SHR logical; 8 SRA.
  - 9 PASS b; 10 SLT signed (result 1 or 0); 11 MUL (low 16 bits of the unsigned product).
  - 12–15 reserved: result 0.
- Flags:
  - `zero_ex` = (result == 0) for every op.
  - `carry_ex` = bit 16 of a+b (ADD) or of a+~b+1 (SUB); 0 for all other ops.
  - `ovf_ex` = signed overflow for ADD and SUB; 0 otherwise.
- Pipeline register:
  - Loads on every edge when `stall_ex` = 0.
  - `valid_id` = 0 loads a bubble: all control outputs, `valid_ex`, result, store data and flags are 0.
  - While `stall_ex` = 1 it loads a bubble on every edge.
- Multiplier FSM:
  - IDLE → BUSY on an edge with `valid_id` ∧ op = 11. Operands are captured and the 4-bit counter cleared.
  - BUSY: one shift-add iteration per cycle; at count = 15 the FSM goes to DONE.
  - DONE: product is ready, `stall_ex` = 0. On the next edge the pipeline register loads the product with the decode-held control fields, and the FSM returns to IDLE.
  - The MUL seen in DONE is not re-issued.
- `stall_ex` = (IDLE ∧ `valid_id` ∧ op = 11) ∨ BUSY. It is combinational.
- Decode holds all `*_id` inputs stable while `stall_ex` = 1.
- Reset: asserting `reset` mid-multiply aborts the multiply. The FSM returns to IDLE and `stall_ex` drops immediately.

## Timing
- All outputs reset to 0 while `reset` = 0.
- Non-MUL ops: 1-cycle latency. Inputs in cycle T appear on outputs in T+1.
- MUL issued in cycle T:
  - `stall_ex` is high in T..T+16 (17 cycles).
  - FSM is in DONE in T+17.
  - Result appears on `ans_ex` in T+18.
  - Bubbles appear on outputs in T+1..T+17.
- Back-to-back MULs: the second is issued in the cycle after DONE, with no idle gap.
- Shift by 0 returns a unchanged. SRA by 15 returns all sign bits.

## Configuration
- `EX_MUL_EN` defined: multiplier FSM present, behaviour as above.
- `EX_MUL_EN` undefined:
  - Op 11 behaves as reserved: result 0, single cycle.
  - `stall_ex` is tied to 0.
  - No FSM or multiplier registers.

## Structure
- Shared package `ex_pkg` holds:
  - op-code constants;
  - the FSM state enum (IDLE, BUSY, DONE);
  - `DW` and `RW` defaults.
- Sub-module `ex_mul_seq` is a sequential shift-add multiplier.
  - Interface: start, a, b, busy, done, product.
  - It is instantiated only under `EX_MUL_EN`.
- The ALU and the pipeline register stay in `execute_stage`.

## Test plan
- Reset: drive `reset` = 0 with random inputs → every output is 0. Release → the first ADD 3+4 gives `ans_ex` = 7 one cycle later.
- ADD 0x7FFF+0x0001 → `ans_ex` = 0x8000, `ovf_ex` = 1, `carry_ex` = 0. SUB 5−5 → 0, `zero_ex` = 1, `carry_ex` = 1.
- Shifts: SRA 0x8000 by 15 → 0xFFFF. SHR 0x8000 by 15 → 0x0001. SHL 0x0001 by 0 → 0x0001.
- MUL 300×200 (with `EX_MUL_EN`):
  - `stall_ex` high for exactly 17 cycles, with bubbles meanwhile.
  - Then `ans_ex` = 0xEA60 (60000) with the held `rd_id` and `wb_en_id`.
  - The following ADD completes one cycle later.
- Reset asserted in cycle 8 of a MUL → `stall_ex` drops immediately and all outputs are 0. After release, a new MUL 2×3 gives 6.
- Load/store pass-through: PASS b = 0x0040 with `mem_en_id` = 1, `mem_rw_id` = 1, `data_id` = 0xBEEF → next cycle `ans_ex` = 0x0040, `DM_data` = 0xBEEF, `mem_en_ex` = `mem_rw_ex` = 1.
